// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave register bank with byte strobes and OKAY/SLVERR responses.
// Optional AXI4_LITE_PROT_CHECK_EN rejects unprivileged (prot[0]=0) accesses.
module axi4_lite_reg_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Holds the ready outputs low until the first edge after reset release.
  logic ready_en_q;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [2:0]            aw_prot_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;

  r_state_e              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  do_write, wr_err, wr_en, rd_err;
  logic                  wr_prot_ok, rd_prot_ok;
  logic [ADDR_WIDTH-1:0] cur_awaddr;
  logic [2:0]            cur_awprot;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [STRB_W-1:0]     cur_wstrb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // A channel completing on this edge is used directly; a held one comes from its latch.
  assign cur_awaddr = aw_held_q ? aw_addr_q : awaddr;
  assign cur_awprot = aw_held_q ? aw_prot_q : awprot;
  assign cur_wdata  = w_held_q  ? w_data_q  : wdata;
  assign cur_wstrb  = w_held_q  ? w_strb_q  : wstrb;

`ifdef AXI4_LITE_PROT_CHECK_EN
  assign wr_prot_ok = cur_awprot[0];
  assign rd_prot_ok = arprot[0];
`else
  logic unused_prot;
  assign unused_prot = ^{cur_awprot, arprot};
  assign wr_prot_ok  = 1'b1;
  assign rd_prot_ok  = 1'b1;
`endif

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign do_write = (w_state_q == WIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_err   = !addr_in_range(cur_awaddr) || !wr_prot_ok;
  assign wr_en    = do_write && !wr_err;
  assign wr_idx   = cur_awaddr[ADDR_LSB +: IDX_W];
  assign rd_err   = !addr_in_range(araddr) || !rd_prot_ok;
  assign rd_idx   = araddr[ADDR_LSB +: IDX_W];

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (do_write) w_state_d = WResp;
      WResp:   if (bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  assign awready = ready_en_q && (w_state_q == WIdle) && !aw_held_q;
  assign wready  = ready_en_q && (w_state_q == WIdle) && !w_held_q;
  assign bvalid  = (w_state_q == WResp);
  assign bresp   = bresp_q;
  assign arready = ready_en_q && (r_state_q == RIdle);
  assign rvalid  = (r_state_q == RData);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q <= 1'b0;
      w_state_q  <= WIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      aw_prot_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      if (do_write) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= awaddr;
          aw_prot_q <= awprot;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (cur_wstrb[b]) regs_q[wr_idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
      end
    end
  end

  // Nonblocking update means a same-edge write is not visible to this capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= RIdle;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_err ? '0 : regs_q[rd_idx];
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule
